// File: rtl/mdu_iter.sv
// mdu_iter: iterative MIPS multiply/divide unit owning the HI/LO registers.
// Ports: clk, rst (sync, active-high), start/op/a/b request (sampled while !busy),
// busy (iteration running), done (one-cycle completion pulse), hi/lo (architectural
// registers), div_by_zero (last completed op was DIV/DIVU with b=0).
// Define MDU_FAST_MUL_EN for a single-cycle combinational MULT/MULTU path.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int W = WIDTH;
`ifdef MDU_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`endif
    state_t         state;
    logic [CNT_W-1:0] cnt;
    // Shared work register: product, or {remainder, dividend/quotient}.
    logic [2*W-1:0] prod;
    logic [W-1:0]   opd;
    logic           is_div, neg_q, neg_r;
    logic           sgn, div_ok;
    logic [W-1:0]   abs_a, abs_b, rem_nx, fix_hi, fix_lo;
    logic [W:0]     div_sh;
    logic [2*W-1:0] prod_neg;
`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_p, fast_r;
`else
    logic [W:0]     mul_sum;
`endif
    always_comb begin
        sgn      = ~op[2] & ~op[0];
        abs_a    = (sgn & a[W-1]) ? -a : a;
        abs_b    = (sgn & b[W-1]) ? -b : b;
        div_sh   = {prod[2*W-1:W], prod[W-1]};
        div_ok   = div_sh >= {1'b0, opd};
        // Remainder always fits W bits once the trial subtract is resolved.
        rem_nx   = div_ok ? div_sh[W-1:0] - opd : div_sh[W-1:0];
        prod_neg = -prod;
        // Low half of a negated double word equals the negated low word.
        fix_lo   = neg_q ? prod_neg[W-1:0] : prod[W-1:0];
        fix_hi   = is_div ? (neg_r ? -prod[2*W-1:W] : prod[2*W-1:W])
                          : (neg_q ? prod_neg[2*W-1:W] : prod[2*W-1:W]);
`ifdef MDU_FAST_MUL_EN
        fast_p   = {{W{1'b0}}, abs_a} * {{W{1'b0}}, abs_b};
        fast_r   = (sgn & (a[W-1] ^ b[W-1])) ? -fast_p : fast_p;
`else
        mul_sum  = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? opd : {W{1'b0}})};
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prod        <= '0;
            opd         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    div_by_zero <= 1'b0;
                    cnt         <= '0;
                    neg_q       <= sgn & (a[W-1] ^ b[W-1]);
                    neg_r       <= sgn & a[W-1];
                    casez (op)
                        3'b00?: begin
`ifdef MDU_FAST_MUL_EN
                            hi   <= fast_r[2*W-1:W];
                            lo   <= fast_r[W-1:0];
                            done <= 1'b1;
`else
                            prod   <= {{W{1'b0}}, abs_b};
                            opd    <= abs_a;
                            is_div <= 1'b0;
                            busy   <= 1'b1;
                            state  <= MUL;
`endif
                        end
                        3'b01?: begin
                            if (b == '0) begin
                                div_by_zero <= 1'b1;
                                done        <= 1'b1;
                            end else begin
                                prod   <= {{W{1'b0}}, abs_a};
                                opd    <= abs_b;
                                is_div <= 1'b1;
                                busy   <= 1'b1;
                                state  <= DIV;
                            end
                        end
                        3'b100: begin
                            hi   <= a;
                            done <= 1'b1;
                        end
                        3'b101: begin
                            lo   <= a;
                            done <= 1'b1;
                        end
                        default: done <= 1'b1;
                    endcase
                end
`ifndef MDU_FAST_MUL_EN
                MUL: begin
                    prod  <= {mul_sum, prod[W-1:1]};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_W'(W - 1)) ? FIX : MUL;
                end
`endif
                DIV: begin
                    prod  <= {rem_nx, prod[W-2:0], div_ok};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CNT_W'(W - 1)) ? FIX : DIV;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter with a 64-bit arithmetic reference model.
module tb_mdu_iter;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
        int           bsy;
    } exp_t;

    exp_t         q[$];
    exp_t         me;
    int           checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
    logic [W-1:0] cur_hi = '0, cur_lo = '0, m_hi = '0, m_lo = '0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("hi", hi, me.hi);
                    chk("lo", lo, me.lo);
                    chk("div_by_zero", div_by_zero, me.dbz);
                    chk("done_cycle", cyc, me.due);
                    chk("busy_cycles", busy_cnt, me.bsy);
                    cur_hi = me.hi;
                    cur_lo = me.lo;
                end
                busy_cnt = 0;
            end else begin
                chk("hi_stable", hi, cur_hi);
                chk("lo_stable", lo, cur_lo);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int          t = 0;
        bit          iter = 1'b0;
        logic [63:0] p;
        longint      sx, sy;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("busy_timeout", 1, 0);
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.dbz = 1'b0;
        case (o)
            3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; iter = !FAST; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; m_hi = p[63:32]; m_lo = p[31:0]; iter = !FAST; end
            3'd2: if (y == 0) e.dbz = 1'b1;
                  else begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); iter = 1'b1; end
            3'd3: if (y == 0) e.dbz = 1'b1;
                  else begin m_lo = x / y; m_hi = x % y; iter = 1'b1; end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.due = cyc + 1 + (iter ? W + 1 : 0);
        e.bsy = iter ? W + 1 : 0;
        q.push_back(e);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 0);
    endtask

    task automatic check_reset_state();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dbz", div_by_zero, 0);
    endtask

    initial begin
        logic [W-1:0] x, y;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd0, 32'hFFFFFFFD, 32'd7);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        issue(3'd3, 32'd7, 32'd2);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        issue(3'd3, 32'd5, 32'd0);
        issue(3'd4, 32'h12345678, 32'd0);
        issue(3'd5, 32'h9ABCDEF0, 32'd0);
        issue(3'd6, 32'hDEADBEEF, 32'd1);
        issue(3'd2, 32'd9, 32'hFFFFFFFC);
        repeat (60) begin
            x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            y = ($urandom_range(0, 6) == 0) ? 32'd0
              : ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 20));
            issue(3'($urandom_range(0, 7)), x, y);
        end
        drain();
        issue(3'd3, 32'd1000, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        a     = $urandom;
        b     = $urandom;
        @(negedge clk);
        start = 1'b0;
        drain();
        issue(3'd3, $urandom, 32'd3);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        cur_hi   = '0;
        cur_lo   = '0;
        m_hi     = '0;
        m_lo     = '0;
        busy_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        repeat (40) @(negedge clk);
        issue(3'd1, 32'd6, 32'd7);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

- Iterative multiply/divide unit for the multi-cycle datapath.
- Executes MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU; the controller stalls the pipeline on `busy` and reads `hi`/`lo` for MFHI/MFLO.
- Width-parametrised, shift-add / restoring-division core with start/busy/done handshake.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4 and even.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only when `busy`=0.
- `op`  in  3: operation. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
- `a`  in  WIDTH: rs operand / dividend / MTHI-MTLO source.
- `b`  in  WIDTH: rt operand / divisor.
- `busy`  out  1: iteration in progress; new starts ignored.
- `done`  out  1: one-cycle pulse, HI/LO final.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.
- `div_by_zero`  out  1: last completed op was DIV/DIVU with `b`=0. Held until next accepted start.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + accepted start:
  - Latch `op`, |a|, |b|.
  - Latch result sign: signed ops only. MULT sign = a⊕b. DIV quotient sign = a⊕b, remainder sign = a.
  - Clear counter.
- Dispatch from IDLE:
  - MULT/MULTU → MUL.
  - DIV/DIVU with `b`≠0 → DIV.
  - DIV/DIVU with `b`=0 → stay IDLE; set `div_by_zero`; pulse `done`; HI/LO unchanged.
  - MTHI: `hi`←`a`. MTLO: `lo`←`a`. Stay IDLE, pulse `done`.
  - Reserved: stay IDLE, pulse `done`, no state change.
- MUL: one shift-add step per cycle on a 2·WIDTH product register. After WIDTH steps → FIX.
- DIV: one restoring step per cycle (shift, trial subtract, set quotient bit). After WIDTH steps → FIX.
- FIX:
  - Apply two's-complement negation per latched signs.
  - Write HI (product high / remainder) and LO (product low / quotient).
  - Pulse `done`; → IDLE.
- Signed divide rules:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - −2^(W−1) / −1 gives LO = −2^(W−1), HI = 0. Wraps; no flag.
- `start` while `busy`=1: ignored, no side effects.
- `rst` at any time, including mid-operation:
  - Abort; → IDLE.
  - `hi`=`lo`=0, `busy`=0, `done`=0, `div_by_zero`=0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Start sampled at edge E0.
- Iterative ops:
  - `busy`=1 from after E0 through the cycle after E0+WIDTH (WIDTH+1 cycles).
  - After E0+WIDTH+1: `done`=1, `busy`=0, HI/LO valid.
  - Latency is WIDTH+1 cycles (33 at WIDTH=32).
- Single-cycle ops (MTHI, MTLO, reserved, divide-by-zero):
  - `busy` never asserted.
  - `done`=1 in the cycle after E0, with HI/LO updated in that cycle.
- Back-to-back: a start in the same cycle `done`=1 is accepted.
- HI/LO are stable except on the `done` edge. No intermediate values are visible.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a combinational WIDTH×WIDTH multiplier.
  - Completion behaves as a single-cycle op: `done` the cycle after E0, no `busy`.
  - MUL state is not generated.
- `MDU_FAST_MUL_EN` undefined: iterative MUL path as specified above. Division is iterative in both cases.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `done` 33 cycles after start, or 1 cycle with `MDU_FAST_MUL_EN`.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (−21). `busy` high exactly 33 cycles in iterative build.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=2 started in the `done` cycle → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Then DIVU b=0 → `done` after 1 cycle, `div_by_zero`=1, HI/LO unchanged.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 → hi=0x12345678, lo=0x9ABCDEF0, each `done` after 1 cycle.
- Start DIVU. Pulse `start` (MULTU) at cycle 5 → ignored; DIVU result intact. Repeat DIVU and assert `rst` at cycle 10 → next cycle `busy`=0, `done`=0, hi=lo=0, and no later `done`.
